// File: rtl/fifo_sync_if.sv
// fifo_sync_if: producer/consumer handshake bundle for fifo_sync.
//   wr_en, data_in     : write request and data (producer side)
//   rd_en, data_out    : read request and registered read data (consumer side)
//   full, empty        : occupancy status
//   overflow, underflow: one-cycle error pulses for rejected requests
// master = the side that drives requests; slave = the FIFO itself.
interface fifo_sync_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, rd_en, data_in,
    input  data_out, full, empty, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, data_in,
    output data_out, full, empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock synchronous FIFO, 2**ADDR_WIDTH words of DATA_WIDTH bits.
//   clk : rising-edge clock for all state
//   rst : synchronous active-low reset; clears pointers, count, data_out and
//         error pulses (memory contents are left as-is)
//   bus : fifo_sync_if slave modport (wr_en/data_in in, rd_en/data_out,
//         full/empty, overflow/underflow out)
// Read data is registered and valid right after the edge that accepts the read.
// A write while full is accepted if a read happens on the same edge.
module fifo_sync #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  fifo_sync_if.slave   bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] C_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  // Status decoded purely from the count register.
  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_rd_ok   = bus.rd_en & ~w_empty;
  // A read on the same edge frees the head slot, so a full FIFO can still take a write.
  assign w_wr_ok   = bus.wr_en & (~w_full | bus.rd_en);
  assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
  assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

  // Storage array: not reset; writes suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && w_wr_ok) begin
      r_mem[w_wr_addr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + C_ONE;
      end
      if (w_rd_ok) begin
        r_rd_ptr   <= r_rd_ptr + C_ONE;
        r_data_out <= r_mem[w_rd_addr];
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      r_overflow  <= bus.wr_en & w_full & ~bus.rd_en;
      r_underflow <= bus.rd_en & w_empty;
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed self-checking bench for fifo_sync (DATA_WIDTH=8, ADDR_WIDTH=5).
module tb_fifo_sync;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fifo_sync_if #(.DATA_WIDTH(8)) bus ();

  fifo_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic f, input logic e,
                            input logic ov, input logic un);
    chk({tag, "_full"},  {31'd0, bus.full},      {31'd0, f});
    chk({tag, "_empty"}, {31'd0, bus.empty},     {31'd0, e});
    chk({tag, "_ovf"},   {31'd0, bus.overflow},  {31'd0, ov});
    chk({tag, "_unf"},   {31'd0, bus.underflow}, {31'd0, un});
  endtask

  logic [7:0] q[$];
  logic [7:0] v;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;

    // 1) reset
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    chk_status("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_dout", {24'd0, bus.data_out}, 32'h00);

    // 2) write 3, read 3
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 8'(i));
    chk("w3_empty", {31'd0, bus.empty}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk($sformatf("r3_dout%0d", i), {24'd0, bus.data_out}, i);
    end
    chk("r3_empty", {31'd0, bus.empty}, 32'd1);

    // 3) fill to 32, overflow with AA, drain in order
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      chk($sformatf("fill_full%0d", i), {31'd0, bus.full}, (i == 31) ? 32'd1 : 32'd0);
    end
    cyc(1'b1, 1'b0, 8'hAA);
    chk_status("ovf", 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00);
    chk_status("ovf_clr", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain%0d", i), {24'd0, bus.data_out}, i);
    end
    chk_status("drained", 1'b0, 1'b1, 1'b0, 1'b0);

    // 4) read when empty
    cyc(1'b0, 1'b1, 8'h00);
    chk_status("unf", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("unf_dout", {24'd0, bus.data_out}, 32'h1F);
    cyc(1'b0, 1'b0, 8'h00);
    chk_status("unf_clr", 1'b0, 1'b1, 1'b0, 1'b0);

    // 5) full + simultaneous wr/rd
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b1, 8'h55);
    chk("fwr_dout", {24'd0, bus.data_out}, 32'h00);
    chk_status("fwr", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 32; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk($sformatf("fwr_rd%0d", i), {24'd0, bus.data_out}, i);
    end
    cyc(1'b0, 1'b1, 8'h00);
    chk("fwr_last", {24'd0, bus.data_out}, 32'h55);
    chk_status("fwr_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Simultaneous wr/rd when empty: write taken, read rejected, no bypass
    cyc(1'b1, 1'b1, 8'h66);
    chk_status("ewr", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ewr_dout", {24'd0, bus.data_out}, 32'h55);
    cyc(1'b0, 1'b1, 8'h00);
    chk("ewr_rd", {24'd0, bus.data_out}, 32'h66);
    chk("ewr_empty", {31'd0, bus.empty}, 32'd1);

    // 6) fill 20 / drain 20 x3 with random data across pointer wrap
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 20; i++) begin
        v = 8'($urandom_range(0, 255));
        q.push_back(v);
        cyc(1'b1, 1'b0, v);
      end
      for (int i = 0; i < 20; i++) begin
        cyc(1'b0, 1'b1, 8'h00);
        v = q.pop_front();
        chk($sformatf("rnd%0d_%0d", rep, i), {24'd0, bus.data_out}, {24'd0, v});
      end
      chk($sformatf("rnd%0d_empty", rep), {31'd0, bus.empty}, 32'd1);
    end

    // Mid-stream reset discards stored data
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hE0 + i));
    rst = 1'b0;
    cyc(1'b1, 1'b1, 8'h77);
    rst = 1'b1;
    chk_status("mrst", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mrst_dout", {24'd0, bus.data_out}, 32'h00);
    cyc(1'b0, 1'b1, 8'h00);
    chk("mrst_unf", {31'd0, bus.underflow}, 32'd1);
    chk("mrst_hold", {24'd0, bus.data_out}, 32'h00);
    cyc(1'b1, 1'b0, 8'h3C);
    cyc(1'b0, 1'b1, 8'h00);
    chk("mrst_new", {24'd0, bus.data_out}, 32'h3C);
    chk("mrst_empty", {31'd0, bus.empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
